// File: rtl/clk_div_multi_pkg.sv
// rtl/clk_div_multi_pkg.sv - shared channel state encoding and ratio limit for clk_div_multi
package clk_div_multi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10
  } chan_state_e;

  // Ratios below this keep a channel in reference-clock bypass.
  localparam int unsigned MIN_ACT_RATIO = 2;

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one glitch-free divider channel; CLK_DIV_MULTI_RISE_PULSE_EN adds o_rise_pulse
module clk_div_chan
  import clk_div_multi_pkg::*;
#(
  parameter int DivRatio_Width = 8
) (
  input  logic                      i_ref_clk,
  input  logic                      i_rst_n,
  input  logic                      i_clk_en,
  input  logic [DivRatio_Width-1:0] i_div_ratio,
  output logic                      o_div_clk,
`ifdef CLK_DIV_MULTI_RISE_PULSE_EN
  output logic                      o_rise_pulse,
`endif
  output logic                      o_active
);

  localparam logic [DivRatio_Width-1:0] ONE   = DivRatio_Width'(1);
  localparam logic [DivRatio_Width-1:0] MIN_R = DivRatio_Width'(MIN_ACT_RATIO);

  chan_state_e               state_q, state_d;
  logic [DivRatio_Width-1:0] cnt_q, cnt_d;
  logic [DivRatio_Width-1:0] act_ratio_q, act_ratio_d;
  logic [DivRatio_Width-1:0] hi_len, lo_len;
  logic                      active_q;
  logic                      start_ok;

  assign hi_len   = act_ratio_q >> 1;
  assign lo_len   = act_ratio_q - hi_len;
  assign start_ok = i_clk_en && (i_div_ratio >= MIN_R);

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= ONE;
      act_ratio_q <= '0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_ratio_q <= act_ratio_d;
      active_q    <= (state_d != IDLE);
    end
  end

  // Enable and ratio are only consulted in IDLE and at the LOW->HIGH boundary.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_ratio_d = act_ratio_q;
    case (state_q)
      IDLE: begin
        act_ratio_d = i_div_ratio;
        cnt_d       = ONE;
        if (start_ok) state_d = HIGH;
      end
      HIGH: begin
        if (cnt_q == hi_len) begin
          state_d = LOW;
          cnt_d   = ONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      LOW: begin
        if (cnt_q == lo_len) begin
          cnt_d = ONE;
          if (!start_ok) begin
            state_d = IDLE;
          end else begin
            act_ratio_d = i_div_ratio;
            state_d     = HIGH;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = ONE;
      end
    endcase
  end

  always_comb begin
    o_div_clk = (state_q == IDLE) ? i_ref_clk : (state_q == HIGH);
    o_active  = active_q;
  end

`ifdef CLK_DIV_MULTI_RISE_PULSE_EN
  // Counter is 1 only in the first HIGH cycle, so this fires once per period.
  logic rise_pulse_q;

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) rise_pulse_q <= 1'b0;
    else          rise_pulse_q <= (state_q == HIGH) && (cnt_q == ONE);
  end

  assign o_rise_pulse = rise_pulse_q;
`endif

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - NUM_CH independent integer clock dividers; CLK_DIV_MULTI_RISE_PULSE_EN adds o_rise_pulse
module clk_div_multi
  import clk_div_multi_pkg::*;
#(
  parameter int DivRatio_Width = 8,
  parameter int NUM_CH         = 2
) (
  input  logic                             i_ref_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_CH-1:0]                i_clk_en,
  input  logic [NUM_CH*DivRatio_Width-1:0] i_div_ratio,
  output logic [NUM_CH-1:0]                o_div_clk,
`ifdef CLK_DIV_MULTI_RISE_PULSE_EN
  output logic [NUM_CH-1:0]                o_rise_pulse,
`endif
  output logic [NUM_CH-1:0]                o_active
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    clk_div_chan #(
      .DivRatio_Width(DivRatio_Width)
    ) u_chan (
      .i_ref_clk   (i_ref_clk),
      .i_rst_n     (i_rst_n),
      .i_clk_en    (i_clk_en[k]),
      .i_div_ratio (i_div_ratio[k*DivRatio_Width +: DivRatio_Width]),
      .o_div_clk   (o_div_clk[k]),
`ifdef CLK_DIV_MULTI_RISE_PULSE_EN
      .o_rise_pulse(o_rise_pulse[k]),
`endif
      .o_active    (o_active[k])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - directed checks for clk_div_multi; CLK_DIV_MULTI_RISE_PULSE_EN enables pulse checks
module tb_clk_div_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  en;
  logic [15:0] ratio;
  logic [1:0]  div_clk;
  logic [1:0]  active;
  logic [1:0]  rise_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0][15:0] cap_d, cap_a, cap_p;

  always #5 clk = ~clk;

  clk_div_multi #(
    .DivRatio_Width(8),
    .NUM_CH        (2)
  ) dut (
    .i_ref_clk   (clk),
    .i_rst_n     (rst_n),
    .i_clk_en    (en),
    .i_div_ratio (ratio),
    .o_div_clk   (div_clk),
`ifdef CLK_DIV_MULTI_RISE_PULSE_EN
    .o_rise_pulse(rise_pulse),
`endif
    .o_active    (active)
  );

`ifndef CLK_DIV_MULTI_RISE_PULSE_EN
  assign rise_pulse = 2'b00;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Samples just after each falling edge, oldest sample in the MSB.
  task automatic capture(input int n, input int chg_at = -1,
                         input logic [1:0] nen = 2'b00, input logic [15:0] nratio = 16'd0);
    cap_d = '0;
    cap_a = '0;
    cap_p = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
        cap_d[c] = {cap_d[c][14:0], div_clk[c]};
        cap_a[c] = {cap_a[c][14:0], active[c]};
        cap_p[c] = {cap_p[c][14:0], rise_pulse[c]};
      end
      if (i == chg_at) begin
        en    = nen;
        ratio = nratio;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    en    = 2'b00;
    ratio = 16'd0;
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en    = 2'b00;
    ratio = 16'd0;
    @(posedge clk);
    #1;
    check_eq("reset_active", 32'(active), 32'h0);
    check_eq("reset_div_hi", 32'(div_clk), 32'h3);
    @(negedge clk);
    #1;
    check_eq("reset_div_lo", 32'(div_clk), 32'h0);
    rst_n = 1'b1;

    // ratio 4 on ch0
    en    = 2'b01;
    ratio = {8'd0, 8'd4};
    capture(12);
    check_eq("r4_div", 32'(cap_d[0]), 32'h0CCC);
    check_eq("r4_act", 32'(cap_a[0]), 32'h0FFF);
    check_eq("r4_ch1_idle", 32'(cap_a[1]), 32'h0);
`ifdef CLK_DIV_MULTI_RISE_PULSE_EN
    check_eq("r4_pulse", 32'(cap_p[0]), 32'h0444);
`endif

    // ratio 5: 2 high / 3 low
    do_reset();
    en    = 2'b01;
    ratio = {8'd0, 8'd5};
    capture(10);
    check_eq("r5_div", 32'(cap_d[0]), 32'h0318);
    check_eq("r5_act", 32'(cap_a[0]), 32'h03FF);

    // ratio 3: 1 high / 2 low
    do_reset();
    en    = 2'b01;
    ratio = {8'd0, 8'd3};
    capture(9);
    check_eq("r3_div", 32'(cap_d[0]), 32'h0124);

    // 4 -> 6 one cycle into HIGH: 1100 then 111000 111000
    do_reset();
    en    = 2'b01;
    ratio = {8'd0, 8'd4};
    capture(16, 0, 2'b01, {8'd0, 8'd6});
    check_eq("chg_div", 32'(cap_d[0]), 32'hCE38);
    check_eq("chg_act", 32'(cap_a[0]), 32'hFFFF);

    // en dropped two cycles into HIGH at ratio 8
    do_reset();
    en    = 2'b01;
    ratio = {8'd0, 8'd8};
    capture(12, 1, 2'b00, {8'd0, 8'd8});
    check_eq("dis_div", 32'(cap_d[0]), 32'h0F00);
    check_eq("dis_act", 32'(cap_a[0]), 32'h0FF0);
    @(posedge clk);
    #1;
    check_eq("dis_div_bypass", 32'(div_clk[0]), 32'h1);

    // ratio 1 then 0 with en=1: bypass
    en    = 2'b01;
    ratio = {8'd0, 8'd1};
    capture(6, 2, 2'b01, {8'd0, 8'd0});
    check_eq("byp_act", 32'(cap_a[0]), 32'h0);
    @(posedge clk);
    #1;
    check_eq("byp_div_hi", 32'(div_clk[0]), 32'h1);

    // ratios 2 and 7, ch1 enabled three cycles later
    do_reset();
    en    = 2'b01;
    ratio = {8'd7, 8'd2};
    capture(16, 2, 2'b11, {8'd7, 8'd2});
    check_eq("dual_ch0_div", 32'(cap_d[0]), 32'hAAAA);
    check_eq("dual_ch0_act", 32'(cap_a[0]), 32'hFFFF);
    check_eq("dual_ch1_div", 32'(cap_d[1]), 32'h1C38);
    check_eq("dual_ch1_act", 32'(cap_a[1]), 32'h1FFF);

    // async reset in the first LOW cycle, then clean restart
    do_reset();
    en    = 2'b01;
    ratio = {8'd0, 8'd4};
    capture(3);
    check_eq("pre_rst_div", 32'(cap_d[0]), 32'h6);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_act", 32'(active), 32'h0);
    @(posedge clk);
    #1;
    check_eq("mid_rst_div", 32'(div_clk), 32'h3);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    capture(8);
    check_eq("post_rst_div", 32'(cap_d[0]), 32'h00CC);
    check_eq("post_rst_act", 32'(cap_a[0]), 32'h00FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
